// File: rtl/tensor_cpu_core_if.sv
// tensor_cpu_core_if: instruction handshake and result bus of tensor_cpu_core.
//
// Handshake: an instruction transfers on a rising clock edge when
// instr_valid_in and instr_ready_out are both high. A master that raises
// instr_valid_in must hold it and instruction_in stable until that edge.
// instr_ready_out never depends on instr_valid_in.
//
// Signals:
//   instr_valid_in    master -> core  instruction present
//   instruction_in    master -> core  [31:24] dst, [23:16] src1/imm, [15:8] src2/imm, [7:0] opcode
//   instr_ready_out   core -> master  core can accept (FSM idle)
//   cpu_output        core -> master  registered result
//   output_valid_out  core -> master  one-cycle pulse when cpu_output updates
//   status_out        core -> master  {parity, overflow, carry, zero, sign}
//   busy_out          core -> master  matrix multiply in progress (RUN or DONE)
//   done_out          core -> master  one-cycle pulse at the end of a multiply
//   fsm_state         core -> master  debug view of the sequencer state
interface tensor_cpu_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  instr_valid_in;
  logic                  instr_ready_out;
  logic [31:0]           instruction_in;
  logic [DATA_WIDTH-1:0] cpu_output;
  logic                  output_valid_out;
  logic [4:0]            status_out;
  logic                  busy_out;
  logic                  done_out;
  logic [1:0]            fsm_state;

  modport master (
    output instr_valid_in, instruction_in,
    input  instr_ready_out, cpu_output, output_valid_out, status_out,
           busy_out, done_out, fsm_state
  );

  modport slave (
    input  instr_valid_in, instruction_in,
    output instr_ready_out, cpu_output, output_valid_out, status_out,
           busy_out, done_out, fsm_state
  );
endinterface

// File: rtl/tensor_cpu_core.sv
// tensor_cpu_core: scalar ALU core with a register file, a tensor register
// file holding A, B and C matrices, and a one-MAC-per-cycle matrix multiply
// sequencer.
//
// Ports:
//   clock_in  system clock, rising edge
//   reset_in  asynchronous active-low reset
//   bus       tensor_cpu_core_if.slave (instruction handshake, result,
//             status, busy/done, debug FSM state)
//
// Tensor RF layout: A at 0..D*D-1, B at D*D..2*D*D-1, C at 2*D*D..3*D*D-1.
module tensor_cpu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int MATRIX_DIM = 4,
  parameter int SATURATE   = 1
) (
  input  logic              clock_in,
  input  logic              reset_in,
  tensor_cpu_core_if.slave  bus
);

  localparam int W      = DATA_WIDTH;
  localparam int D      = MATRIX_DIM;
  localparam int TSIZE  = 3 * D * D;
  localparam int B_BASE = D * D;
  localparam int C_BASE = 2 * D * D;
  localparam int TW     = $clog2(TSIZE);
  localparam int IW     = (D > 1) ? $clog2(D) : 1;
  localparam int RIW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int ACC_W  = 2 * W + $clog2(D);
  localparam logic [IW-1:0] LAST = IW'(D - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_SUB    = 8'h01;
  localparam logic [7:0] OP_AND    = 8'h02;
  localparam logic [7:0] OP_OR     = 8'h03;
  localparam logic [7:0] OP_XOR    = 8'h04;
  localparam logic [7:0] OP_TLOADI = 8'h06;
  localparam logic [7:0] OP_TLOAD  = 8'h07;
  localparam logic [7:0] OP_ADDI   = 8'h09;
  localparam logic [7:0] OP_SUBI   = 8'h0A;
  localparam logic [7:0] OP_CLEAR  = 8'h0D;
  localparam logic [7:0] OP_READ   = 8'h0F;
  localparam logic [7:0] OP_TREAD  = 8'h10;
  localparam logic [7:0] OP_MATMUL = 8'h11;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic [W-1:0]   regs [NUM_REGS];
  logic [W-1:0]   t_rf [TSIZE];
  logic [IW-1:0]  i, j, k;
  logic signed [ACC_W-1:0] acc;
  logic [W-1:0]   out_q;
  logic           out_valid_q;
  logic [4:0]     status_q;

  // Register index is the instruction field modulo NUM_REGS.
  function automatic logic [RIW-1:0] reg_idx(input logic [7:0] f);
    logic [8:0] m;
    m = {1'b0, f} % 9'(NUM_REGS);
    return m[RIW-1:0];
  endfunction

  logic [7:0] f_dst, f_s1, f_s2, opcode;
  assign {f_dst, f_s1, f_s2, opcode} = bus.instruction_in;

  logic accept;
  assign accept = bus.instr_valid_in & bus.instr_ready_out;

  logic [RIW-1:0] r_dst, r_s1, r_s2;
  assign r_dst = reg_idx(f_dst);
  assign r_s1  = reg_idx(f_s1);
  assign r_s2  = reg_idx(f_s2);

  // 8-bit immediates are taken as signed and resized to the datapath width.
  logic [W-1:0] imm, timm;
  assign imm  = W'($signed(f_s2));
  assign timm = W'($signed(f_s1));

  logic dst_ok, src_ok;
  assign dst_ok = int'(f_dst) < TSIZE;
  assign src_ok = int'(f_s1) < TSIZE;

  // ---------------- scalar ALU ----------------
  logic [W-1:0] op_a, op_b, alu_res;
  logic [W:0]   wide;
  logic         alu_c, alu_v, is_alu;

  always_comb begin
    op_a    = regs[r_s1];
    op_b    = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm : regs[r_s2];
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    is_alu  = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      OP_SUB, OP_SUBI: begin
        // Top bit of the widened difference is the unsigned borrow.
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: is_alu = 1'b0;
    endcase
  end

  // ---------------- MAC datapath ----------------
  logic [TW-1:0] a_idx, b_idx, c_idx;
  assign a_idx = TW'(int'(i) * D + int'(k));
  assign b_idx = TW'(B_BASE + int'(k) * D + int'(j));
  assign c_idx = TW'(C_BASE + int'(i) * D + int'(j));

  logic signed [ACC_W-1:0] a_ext, b_ext, sum;
  assign a_ext = ACC_W'($signed(t_rf[a_idx]));
  assign b_ext = ACC_W'($signed(t_rf[b_idx]));
  assign sum   = acc + a_ext * b_ext;

  logic [W-1:0] c_val;
  always_comb begin
    c_val = sum[W-1:0];
    if (SATURATE != 0) begin
      if (sum > SAT_MAX)      c_val = SAT_MAX[W-1:0];
      else if (sum < SAT_MIN) c_val = SAT_MIN[W-1:0];
    end
  end

  logic last_mac;
  assign last_mac = (state == RUN) && (i == LAST) && (j == LAST) && (k == LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && opcode == OP_MATMUL) state_next = RUN;
      RUN:     if (last_mac) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready_out = 1'b0;
    bus.busy_out        = 1'b0;
    bus.done_out        = 1'b0;
    case (state)
      IDLE:    bus.instr_ready_out = 1'b1;
      RUN:     bus.busy_out = 1'b1;
      DONE: begin
        bus.busy_out = 1'b1;
        bus.done_out = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- state registers ----------------
  // Instructions are only accepted in IDLE and the MAC only writes in RUN,
  // so the two tensor RF writers never collide.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
      for (int n = 0; n < TSIZE; n++)    t_rf[n] <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      status_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        if (is_alu) begin
          regs[r_dst] <= alu_res;
          out_q       <= alu_res;
          out_valid_q <= 1'b1;
          status_q    <= {^alu_res, alu_v, alu_c, alu_res == '0, alu_res[W-1]};
        end else begin
          case (opcode)
            OP_TLOADI: if (dst_ok) t_rf[TW'(f_dst)] <= timm;
            OP_TLOAD:  if (dst_ok) t_rf[TW'(f_dst)] <= regs[r_s1];
            OP_READ: begin
              out_q       <= regs[r_s1];
              out_valid_q <= 1'b1;
            end
            OP_TREAD: begin
              out_q       <= src_ok ? t_rf[TW'(f_s1)] : '0;
              out_valid_q <= 1'b1;
            end
            OP_MATMUL: begin
              i   <= '0;
              j   <= '0;
              k   <= '0;
              acc <= '0;
            end
            OP_CLEAR: for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
            default: ;
          endcase
        end
      end
      if (state == RUN) begin
        // k innermost, then j, then i; the last k of each dot product writes C.
        if (k == LAST) begin
          t_rf[c_idx] <= c_val;
          acc         <= '0;
          k           <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          acc <= sum;
          k   <= k + 1'b1;
        end
      end
    end
  end

  assign bus.cpu_output       = out_q;
  assign bus.output_valid_out = out_valid_q;
  assign bus.status_out       = status_q;
  assign bus.fsm_state        = state;

endmodule

// File: tb/tb_tensor_cpu_core.sv
`timescale 1ns/1ps
module tb_tensor_cpu_core;

  localparam int W  = 8;
  localparam int NR = 8;
  localparam int D  = 4;
  localparam int TS = 3 * D * D;

  localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_AND = 8'h02,
                         OP_OR = 8'h03, OP_XOR = 8'h04, OP_TLOADI = 8'h06,
                         OP_TLOAD = 8'h07, OP_ADDI = 8'h09, OP_SUBI = 8'h0A,
                         OP_CLEAR = 8'h0D, OP_READ = 8'h0F, OP_TREAD = 8'h10,
                         OP_MATMUL = 8'h11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld = 1'b0;
  logic [31:0] ins = '0;

  tensor_cpu_core_if #(.DATA_WIDTH(W)) bus_sat ();
  tensor_cpu_core_if #(.DATA_WIDTH(W)) bus_trn ();
  assign bus_sat.instr_valid_in = vld;
  assign bus_sat.instruction_in = ins;
  assign bus_trn.instr_valid_in = vld;
  assign bus_trn.instruction_in = ins;

  tensor_cpu_core #(.DATA_WIDTH(W), .NUM_REGS(NR), .MATRIX_DIM(D), .SATURATE(1))
    dut_sat (.clock_in(clk), .reset_in(rst_n), .bus(bus_sat));
  tensor_cpu_core #(.DATA_WIDTH(W), .NUM_REGS(NR), .MATRIX_DIM(D), .SATURATE(0))
    dut_trn (.clock_in(clk), .reset_in(rst_n), .bus(bus_trn));

  // ---------------- counts and checks ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int last_wait = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries are {status, data}; the two cores differ only in C results.
  logic [12:0] exp_sat[$];
  logic [12:0] exp_trn[$];
  int          m_r[NR];
  int          m_ts[TS];
  int          m_tt[TS];
  logic [4:0]  m_st;

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return 128;   // -128 as an 8-bit pattern
    return v & 255;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NR; n++) m_r[n] = 0;
    for (int n = 0; n < TS; n++) begin
      m_ts[n] = 0;
      m_tt[n] = 0;
    end
    m_st = '0;
    exp_sat.delete();
    exp_trn.delete();
  endtask

  task automatic model_step(input logic [31:0] x);
    logic [7:0] fd, f1, f2, op;
    int a, b, full, sr, res, s_s, s_t;
    bit alu, c, v;
    logic [7:0] r8;
    {fd, f1, f2, op} = x;
    a   = m_r[int'(f1) % NR];
    b   = (op == OP_ADDI || op == OP_SUBI) ? int'(f2) : m_r[int'(f2) % NR];
    alu = 1'b1;
    c   = 1'b0;
    v   = 1'b0;
    res = 0;
    case (op)
      OP_ADD, OP_ADDI: begin
        full = a + b;
        res  = full & 255;
        c    = full > 255;
        sr   = to_signed8(a) + to_signed8(b);
        v    = (sr > 127) || (sr < -128);
      end
      OP_SUB, OP_SUBI: begin
        res = (a - b) & 255;
        c   = a < b;
        sr  = to_signed8(a) - to_signed8(b);
        v   = (sr > 127) || (sr < -128);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: alu = 1'b0;
    endcase
    if (alu) begin
      m_r[int'(fd) % NR] = res;
      r8   = 8'(res);
      m_st = {^r8, v, c, r8 == 8'h00, r8[7]};
      exp_sat.push_back({m_st, r8});
      exp_trn.push_back({m_st, r8});
    end else begin
      case (op)
        OP_TLOADI: if (int'(fd) < TS) begin
          m_ts[fd] = int'(f1);
          m_tt[fd] = int'(f1);
        end
        OP_TLOAD: if (int'(fd) < TS) begin
          m_ts[fd] = a;
          m_tt[fd] = a;
        end
        OP_READ: begin
          exp_sat.push_back({m_st, 8'(a)});
          exp_trn.push_back({m_st, 8'(a)});
        end
        OP_TREAD: begin
          exp_sat.push_back({m_st, (int'(f1) < TS) ? 8'(m_ts[f1]) : 8'h00});
          exp_trn.push_back({m_st, (int'(f1) < TS) ? 8'(m_tt[f1]) : 8'h00});
        end
        OP_MATMUL: begin
          for (int r = 0; r < D; r++) begin
            for (int q = 0; q < D; q++) begin
              s_s = 0;
              s_t = 0;
              for (int p = 0; p < D; p++) begin
                s_s += to_signed8(m_ts[r*D+p]) * to_signed8(m_ts[D*D+p*D+q]);
                s_t += to_signed8(m_tt[r*D+p]) * to_signed8(m_tt[D*D+p*D+q]);
              end
              m_ts[2*D*D + r*D + q] = clamp8(s_s);
              m_tt[2*D*D + r*D + q] = s_t & 255;
            end
          end
        end
        OP_CLEAR: for (int n = 0; n < NR; n++) m_r[n] = 0;
        default: ;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  function automatic logic [31:0] mk(input logic [7:0] d, input logic [7:0] s1,
                                     input logic [7:0] s2, input logic [7:0] op);
    return {d, s1, s2, op};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [31:0] x);
    int n = 0;
    vld = 1'b1;
    ins = x;
    while (bus_sat.instr_ready_out !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got ready=0 after %0d cycles expected ready=1", n);
    end else begin
      model_step(x);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic matmul_timed();
    int low = 0;
    int dn  = 0;
    issue(mk(0, 0, 0, OP_MATMUL));
    while (bus_sat.instr_ready_out !== 1'b1 && low < 300) begin
      low++;
      if (bus_sat.done_out === 1'b1) dn++;
      @(negedge clk);
    end
    check("ready_low_cycles", 32'(low), 32'(D*D*D + 1));
    check("done_pulses", 32'(dn), 32'd1);
  endtask

  // ---------------- monitors ----------------
  logic [12:0] e_sat, e_trn;

  always @(negedge clk) begin
    if (bus_sat.output_valid_out === 1'b1) begin
      if (exp_sat.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sat_unexpected_output: got 0x%0h expected none", bus_sat.cpu_output);
      end else begin
        e_sat = exp_sat.pop_front();
        check("sat_status_data", {19'b0, bus_sat.status_out, bus_sat.cpu_output}, {19'b0, e_sat});
      end
    end
  end

  always @(negedge clk) begin
    if (bus_trn.output_valid_out === 1'b1) begin
      if (exp_trn.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL trn_unexpected_output: got 0x%0h expected none", bus_trn.cpu_output);
      end else begin
        e_trn = exp_trn.pop_front();
        check("trn_status_data", {19'b0, bus_trn.status_out, bus_trn.cpu_output}, {19'b0, e_trn});
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [7:0] rnd_ops[7] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SUBI};

  initial begin
    int r;
    logic [7:0] op;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus_sat.instr_ready_out), 32'd1);
    check("rst_busy", 32'(bus_sat.busy_out), 32'd0);
    check("rst_done", 32'(bus_sat.done_out), 32'd0);
    check("rst_valid", 32'(bus_sat.output_valid_out), 32'd0);
    check("rst_out", 32'(bus_sat.cpu_output), 32'd0);
    check("rst_status", 32'(bus_sat.status_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_sat.instr_ready_out), 32'd1);

    // 1: signed overflow into 0x80
    issue(mk(1, 0, 8'h7F, OP_ADDI));
    issue(mk(2, 1, 8'h01, OP_ADDI));
    issue(mk(0, 2, 0, OP_READ));
    check("t1_out", 32'(bus_sat.cpu_output), 32'h80);
    check("t1_status", 32'(bus_sat.status_out), 32'b11001);

    // 2: identity times ramp
    for (int n = 0; n < D*D; n++) issue(mk(8'(n), (n / D == n % D) ? 8'd1 : 8'd0, 0, OP_TLOADI));
    for (int n = 0; n < D*D; n++) issue(mk(8'(D*D + n), 8'(n), 0, OP_TLOADI));
    matmul_timed();
    for (int n = 0; n < D*D; n++) begin
      issue(mk(0, 8'(2*D*D + n), 0, OP_TREAD));
      check("t2_c", 32'(bus_sat.cpu_output), 32'(n));
    end

    // 3: saturation versus truncation
    for (int n = 0; n < 2*D*D; n++) issue(mk(8'(n), 8'h7F, 0, OP_TLOADI));
    matmul_timed();
    for (int n = 0; n < D*D; n++) begin
      issue(mk(0, 8'(2*D*D + n), 0, OP_TREAD));
      check("t3_sat", 32'(bus_sat.cpu_output), 32'h7F);
      check("t3_trunc", 32'(bus_trn.cpu_output), 32'h04);
    end

    // 4: instruction held valid across a multiply
    issue(mk(0, 0, 0, OP_MATMUL));
    issue(mk(3, 1, 2, OP_ADD));
    check("t4_held_wait", 32'(last_wait), 32'(D*D*D + 1));
    check("t4_add", 32'(bus_sat.cpu_output), 32'h7F + 32'h80);

    // 5: reset in the middle of RUN
    vld = 1'b1;
    ins = mk(0, 0, 0, OP_MATMUL);
    @(negedge clk);
    vld = 1'b0;
    repeat (19) @(negedge clk);
    check("t5_busy_before", 32'(bus_sat.busy_out), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_ready_in_reset", 32'(bus_sat.instr_ready_out), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", 32'(bus_sat.instr_ready_out), 32'd1);
    check("t5_busy", 32'(bus_sat.busy_out), 32'd0);
    issue(mk(0, 8'(2*D*D), 0, OP_TREAD));
    check("t5_c0", 32'(bus_sat.cpu_output), 32'd0);
    issue(mk(0, 0, 0, OP_TREAD));
    check("t5_a0", 32'(bus_sat.cpu_output), 32'd0);

    // 6: out-of-range tensor address
    for (int n = 0; n < TS; n++) issue(mk(8'(n), 8'($urandom_range(0, 255)), 0, OP_TLOADI));
    issue(mk(8'(TS), 8'h5A, 0, OP_TLOADI));
    issue(mk(0, 8'(TS), 0, OP_TREAD));
    check("t6_oob_read", 32'(bus_sat.cpu_output), 32'd0);
    check("t6_oob_valid", 32'(bus_sat.output_valid_out), 32'd1);
    for (int n = 0; n < TS; n++) issue(mk(0, 8'(n), 0, OP_TREAD));

    // Random mix against the model
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        op = rnd_ops[$urandom_range(0, 6)];
        issue(mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), op));
      end else if (r < 55) issue(mk(8'($urandom_range(0, TS + 3)), 8'($urandom_range(0, 255)), 0, OP_TLOADI));
      else if (r < 62) issue(mk(8'($urandom_range(0, TS + 3)), 8'($urandom_range(0, 255)), 0, OP_TLOAD));
      else if (r < 75) issue(mk(0, 8'($urandom_range(0, 255)), 0, OP_READ));
      else if (r < 91) issue(mk(0, 8'($urandom_range(0, TS + 3)), 0, OP_TREAD));
      else if (r < 94) issue(mk(0, 0, 0, OP_MATMUL));
      else if (r < 96) issue(mk(0, 0, 0, OP_CLEAR));
      else issue(mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 8'h20));
    end
    for (int n = 2*D*D; n < TS; n++) issue(mk(0, 8'(n), 0, OP_TREAD));

    repeat (4) @(negedge clk);
    check("sat_queue_drained", 32'(exp_sat.size()), 32'd0);
    check("trn_queue_drained", 32'(exp_trn.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tensor_cpu_core.md
Name: tensor_cpu_core

Overview:
- Parametrised successor of the tiny 4-bit CPU. It has a configurable scalar datapath, a configurable register count, and an NxN tensor unit.
- A valid/ready instruction handshake replaces the free-running instruction bus.
- Matrix multiply is a sequenced, stalling operation: one MAC per cycle, with optional saturation. The previous one-shot, clock-XOR tensor path is removed.
- Sits between the instruction sequencer/testbench and the top-level output pins.

Parameters:
- DATA_WIDTH, 8, scalar and tensor element width (signed).
- NUM_REGS, 8, scalar register count; index = instr field modulo NUM_REGS.
- MATRIX_DIM, 4, D. Tensor RF has 3*D*D elements: A at 0..D²-1, B at D²..2D²-1, C at 2D²..3D²-1.
- SATURATE, 1. 1 = C results clamp to the signed DATA_WIDTH range; 0 = truncate to the low DATA_WIDTH bits.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous active-low reset.
- instr_valid_in  input  1  instruction present.
- instr_ready_out  output  1  core can accept; equals (state==IDLE).
- instruction_in  input  32  [31:24] dst, [23:16] src1/imm, [15:8] src2/imm, [7:0] opcode.
- cpu_output  output  DATA_WIDTH  registered result.
- output_valid_out  output  1  one-cycle pulse when cpu_output is updated.
- status_out  output  5  {parity, overflow, carry, zero, sign}.
- busy_out  output  1  high in RUN and DONE.
- done_out  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (async, reset_in=0) clears:
  - all scalar regs, tensor RF, accumulator, cpu_output and status to 0;
  - output_valid_out=0, done_out=0, busy_out=0;
  - FSM to IDLE, so instr_ready_out=1 once reset deasserts.
- Reset asserted mid-matmul aborts the operation; partial C contents are cleared.
- Accept = instr_valid_in & instr_ready_out at a rising edge. Every accepted instruction executes in that edge; there is no other latency for scalar ops.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR: R[dst] = R[s1] op R[s2].
  - 0x09 ADDI, 0x0A SUBI: R[dst] = R[s1] op imm. imm = instr[15:8] truncated/sign-taken to DATA_WIDTH.
  - 0x06 TLOADI: T[dst] = instr[23:16] truncated to DATA_WIDTH.
  - 0x07 TLOAD: T[dst] = R[s1].
  - 0x0F READ: cpu_output = R[s1].
  - 0x10 TREAD: cpu_output = T[instr[23:16]].
  - 0x11 MATMUL: start the sequencer.
  - 0x0D CLEAR: zeroes the scalar regs only.
  - Any other opcode: accepted as a no-op.
- ALU ops:
  - Wrap modulo 2^DATA_WIDTH.
  - cpu_output = result; output_valid_out pulses the next cycle, as does READ/TREAD.
  - Status updates on ALU ops only:
    - carry = unsigned carry/borrow;
    - overflow = signed overflow (logic ops: 0);
    - zero = result==0;
    - sign = MSB;
    - parity = XOR of result bits.
- Tensor addresses ≥ 3*D*D: writes ignored; TREAD returns 0 (output_valid_out still pulses).
- MATMUL FSM:
  - States: IDLE, RUN, DONE.
  - IDLE → RUN on an accepted 0x11. Indices i, j, k and acc are cleared.
  - RUN: one cycle per (i,j,k), k innermost then j then i.
    - sum = acc + A[i*D+k]*B[k*D+j], using full-precision signed 2*DATA_WIDTH+clog2(D) bits.
    - k<D-1: acc = sum.
    - k==D-1: C[i*D+j] = clamp/truncate(sum); acc = 0.
  - RUN lasts exactly D³ cycles. After the cycle with i=j=k=D-1 → DONE.
  - DONE lasts 1 cycle: done_out=1, then → IDLE.
  - instr_ready_out is low for exactly D³+1 cycles after the accept edge.
  - A and B are unchanged by the operation.
- MATMUL issued while busy cannot occur, because ready is low. An instruction held valid during busy is accepted on the first IDLE edge.
- Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].

Test Plan:
1. Reset, ADDI R1=R0+0x7F, then ADDI R2=R1+1, then READ R2 → cpu_output=0x80, status overflow=1, sign=1, zero=0, carry=0, parity=1.
2. TLOADI A=identity (1 on diagonal), B[n]=n for n=0..15, MATMUL, wait for done_out, TREAD 32..47 → C[n]=n. instr_ready_out low for exactly 65 cycles; done_out pulses once.
3. A all 0x7F, B all 0x7F, SATURATE=1, MATMUL → every C=0x7F. With SATURATE=0 → every C = low 8 bits of 4*127*127 = 0x04.
4. Hold a valid ADD during MATMUL → not accepted until the first IDLE edge, then executes exactly once.
5. Assert reset_in low at cycle 20 of RUN → immediately instr_ready_out=1 after release, busy_out=0, TREAD C[0]=0, TREAD A[0]=0.
6. TLOADI to address 48 then TREAD 48 → returns 0, output_valid_out pulses, and no tensor element changes.
